ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 104 ++++++++++
 tb/tb_ifetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential PC generation into a small in-order
// fetch buffer with decode backpressure and execute-stage redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int PW = (BUF_DEPTH == 4) ? 2 : 1;
  localparam int CW = PW + 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [29:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic [29:0] pc_mem  [BUF_DEPTH];
  logic [31:0] ins_mem [BUF_DEPTH];

  logic full;
  logic pop;
  logic space;
  logic push;

  // Word-aligned PC kept as 30 bits so the low address bits are always zero
  assign imem_addr = {fetch_pc, 2'b00};

  assign full  = (count == CW'(BUF_DEPTH));
  assign pop   = if_valid && id_ready;
  assign space = !full || pop;
  assign push  = imem_valid && space;

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? {pc_mem[rd_ptr], 2'b00} : 32'h0;
  assign if_instr = if_valid ? ins_mem[rd_ptr] : 32'h0;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + CW'(1);
      pop && !push: count_nxt = count - CW'(1);
      default:      count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (imem_valid && !space) state_nxt = HOLD;
      HOLD:    if (pop) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC[31:2];
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      state    <= RUN;
      fetch_pc <= redirect_pc[31:2];
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) begin
        fetch_pc <= fetch_pc + 30'd1;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table plus hand-written
// reset, backpressure and slow-memory sequences.
module tb_ifetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory model: word depends on address; garbage when not valid
  assign imem_data = imem_valid ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  typedef struct {
    logic        rdy;
    logic        iv;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rdy, logic iv, logic rv,
                              logic [31:0] rpc, logic ev,
                              logic [31:0] epc, logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.iv = iv; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic ev, logic [31:0] epc,
                         logic [31:0] eaddr);
    chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, ev});
    chk({tag, ".addr"}, imem_addr, eaddr);
    if (ev) begin
      chk({tag, ".pc"}, if_pc, epc);
      chk({tag, ".instr"}, if_instr, epc ^ K);
    end
  endtask

  task automatic step(logic rdy, logic iv, logic rv, logic [31:0] rpc);
    id_ready       = rdy;
    imem_valid     = iv;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.valid", {31'b0, if_valid}, 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.instr", if_instr, 32'h0);
    id_ready = 1'b0;
    imem_valid = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_seq [3];
    rst_n = 1'b0;
    id_ready = 1'b0;
    imem_valid = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Streaming from reset
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h0, 32'h4));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h4, 32'h8));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h8, 32'hC));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'hC, 32'h10));
    // Backpressure fills buffer, then HOLD freezes address
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h14));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h14));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h14));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h14));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h10, 32'h18));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h14, 32'h1C));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h18, 32'h20));
    // Redirect with full buffer, misaligned target
    tbl.push_back(mk(1, 1, 1, 32'h0000_0103, 0, 32'h0, 32'h100));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h100, 32'h104));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 32'h104));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h104, 32'h108));
    // Wrap around the top of the address space
    tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFF8));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h0, 32'h4));

    // Reset is asserted with imem_valid high; nothing must be accepted
    #1;
    chk("por.valid", {31'b0, if_valid}, 32'd0);
    chk("por.addr", imem_addr, 32'h0);
    chk("por.pc", if_pc, 32'h0);
    chk("por.instr", if_instr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    imem_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("por.addr2", imem_addr, 32'h0);

    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].iv, tbl[i].rv, tbl[i].rpc);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
    end

    // Mid-stream reset with two entries buffered
    step(0, 1, 0, 0);
    chk_out("pre_rst", 1'b1, 32'h0, 32'h8);
    do_reset();
    chk_out("post_rst", 1'b0, 32'h0, 32'h0);

    // Backpressure from reset: five cycles of id_ready low
    for (int c = 0; c < 5; c++) step(0, 1, 0, 0);
    chk_out("bp.full", 1'b1, 32'h0, 32'h8);
    exp_seq = '{32'h0, 32'h4, 32'h8};
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp.order%0d", j), if_pc, exp_seq[j]);
      chk($sformatf("bp.v%0d", j), {31'b0, if_valid}, 32'd1);
      step(1, 1, 0, 0);
    end

    // Slow memory: three wait cycles per word
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        step(1, 0, 0, 0);
        chk_out($sformatf("slow%0d.wait%0d", k, w), 1'b0, 32'h0,
                32'(4 * k));
      end
      step(1, 1, 0, 0);
      chk_out($sformatf("slow%0d.got", k), 1'b1, 32'(4 * k),
              32'(4 * k + 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
